nibble_serial_adder: RTL and testbench

Multi-cycle adder/subtractor for WIDTH = 4*NIBBLES-bit operands, built on a single 4-bit ripple-carry slice.
- Each cycle it adds one nibble, least-significant first, and registers the slice carry into the next cycle.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready).
- Trades latency for area: one 4-bit adder instead of a WIDTH-bit adder.

---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_four_bit_adder.sv | 14 +
 rtl/nibble_serial_adder.sv | 114 +++++++++++
 tb/tb_nibble_serial_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM encoding.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_four_bit_adder.sv
// Four-bit ripple-carry adder cell used as the single arithmetic slice.
module four_bit_adder
  import nibble_serial_adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit slice,
// processing one nibble per cycle, least-significant nibble first.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | one nibble per cycle through the slice, carry kept in carry_q
// DONE  | result held on sum/carry_out/overflow until out_ready
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int WIDTH  = NIBBLE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q, carry_out_q, overflow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NIBBLE_W-1:0] slice_s;
  logic               slice_co;
  logic               last;
  logic [WIDTH-1:0]   sum_next;

  four_bit_adder u_slice (
    .s  (slice_s),
    .co (slice_co),
    .x  (a_q[NIBBLE_W-1:0]),
    .y  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q)
  );

  assign last     = (cnt_q == CNT_W'(NIBBLES - 1));
  // New slice result enters at the top; earlier nibbles move down toward bit 0.
  assign sum_next = (sum_q >> NIBBLE_W) | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; in_valid is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand capture, nibble shifting, counter and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub | carry_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          carry_q <= slice_co;
          if (last) begin
            carry_out_q <= slice_co;
            // carry into the MSB (a3^b3^s3) differing from carry out of it
            overflow_q  <= a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1] ^ slice_s[NIBBLE_W-1] ^ slice_co;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at NIBBLES=4 plus a NIBBLES=1 instance.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, carry_in, sub, out_valid, out_ready, carry_out, overflow;
  logic [15:0] op_a, op_b, sum;

  logic        in_valid1, in_ready1, carry_in1, sub1, out_valid1, out_ready1, carry_out1, overflow1;
  logic [3:0]  op_a1, op_b1, sum1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sb;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .carry_in(carry_in1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .carry_out(carry_out1), .overflow(overflow1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, accept them, then count cycles until out_valid.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sb, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; carry_in = cin; sub = sb; in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Consume the result and confirm return to IDLE.
  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_done", 32'(in_ready), 32'd1);
    chk("out_valid_after_done", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] held_sum;
    logic        held_co, held_ov;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; op_a1 = '0; op_b1 = '0; carry_in1 = 1'b0; sub1 = 1'b0;

    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_flags", {30'd0, carry_out, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("vec%0d_carry_out", i), 32'(carry_out), 32'(vecs[i].co));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
      finish_op();
    end

    // Reset mid-RUN: the last result left both flags set, so a clear is visible.
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'hFFFF; carry_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_sum", 32'(sum), 32'd0);
    chk("midrun_reset_flags", {30'd0, carry_out, overflow}, 32'd0);
    chk("midrun_reset_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_partial_result", 32'(out_valid), 32'd0);

    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
    chk("post_reset_latency", 32'(lat), 32'd4);
    chk("post_reset_sum", 32'(sum), 32'h1000);
    chk("post_reset_flags", {30'd0, carry_out, overflow}, 32'd0);
    finish_op();

    // Backpressure: new operands pulsed while the result is held.
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    held_sum = sum; held_co = carry_out; held_ov = overflow;
    chk("bp_sum", 32'(held_sum), 32'h8000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      op_a = 16'h1111 * 16'(k + 1); op_b = 16'h2222; in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_sum_hold", k), 32'(sum), 32'h8000);
      chk($sformatf("bp%0d_flags_hold", k), {30'd0, carry_out, overflow}, 32'b01);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op();
    repeat (6) @(posedge clk);
    #1;
    chk("bp_ops_not_captured", 32'(out_valid), 32'd0);
    chk("bp_sum_retained", 32'(sum), 32'h8000);

    // Single-nibble build.
    @(negedge clk);
    op_a1 = 4'h9; op_b1 = 4'h8; carry_in1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
    chk("n1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("n1_out_valid_early", 32'(out_valid1), 32'd0);
    @(posedge clk); #1;
    chk("n1_out_valid", 32'(out_valid1), 32'd1);
    chk("n1_sum", 32'(sum1), 32'h1);
    chk("n1_flags", {30'd0, carry_out1, overflow1}, 32'b11);
    @(negedge clk);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("n1_in_ready_after", 32'(in_ready1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
